serial_word_tx: RTL and testbench

- Upstream serializer for the serial divisible-by-5 checker FSM.
- Accepts one parallel word with a bit length over a valid/ready handshake.
- Shifts the word out MSB-first, one bit per clock, on serial_ip, with framing strobes; the downstream checker uses sof to restart its remainder.
- Single clock; all outputs registered or decoded from registered state.

---
 rtl/serial_word_tx_pkg.sv | 29 ++
 rtl/serial_word_tx_if.sv | 37 +++
 rtl/serial_word_tx.sv | 103 ++++++++++
 tb/tb_serial_word_tx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_word_tx_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
// Shared types and helpers for the serial word transmitter.
//   state_e  : transmitter FSM states (idle, shifting bits, inter-word gap)
//   LEN_W    : length-field width for the default 8-bit word
//   eff_len  : clamps a requested bit length into 1..width
// ---------------------------------------------------------------------------
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;
    localparam int LEN_W         = $clog2(DEFAULT_WIDTH + 1);

    // A length of zero, or anything longer than the word, means "send the
    // whole word"; every other value is taken as-is.
    function automatic int unsigned eff_len(input int unsigned len,
                                            input int unsigned width);
        if ((len == 0) || (len > width)) begin
            return width;
        end
        return len;
    endfunction

endpackage

// File: rtl/serial_word_tx_if.sv
// ---------------------------------------------------------------------------
// serial_word_tx_if
// Bundles the word-load handshake and the serial output strobes.
//   load_valid/load_ready : word handshake (producer -> transmitter)
//   load_data/load_len    : word and its bit length
//   serial_ip, bit_valid  : serial bit stream and its qualifier
//   sof/eof               : first/last bit markers
//   busy                  : transmitter not idle
// master = word producer, slave = transmitter.
// ---------------------------------------------------------------------------
interface serial_word_tx_if #(
    parameter int WIDTH = 8
) ();

    localparam int LW = $clog2(WIDTH + 1);

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [LW-1:0]    load_len;
    logic             serial_ip;
    logic             bit_valid;
    logic             sof;
    logic             eof;
    logic             busy;

    modport master (
        output load_valid, load_data, load_len,
        input  load_ready, serial_ip, bit_valid, sof, eof, busy
    );

    modport slave (
        input  load_valid, load_data, load_len,
        output load_ready, serial_ip, bit_valid, sof, eof, busy
    );

endinterface

// File: rtl/serial_word_tx.sv
// ---------------------------------------------------------------------------
// serial_word_tx
// Takes one parallel word plus a bit length over a valid/ready handshake and
// shifts it out MSB-first, one bit per clock, followed by GAP idle cycles.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : serial_word_tx_if slave (load handshake in, serial strobes out)
// ---------------------------------------------------------------------------
module serial_word_tx
    import serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_word_tx_if.slave bus
);

    localparam int LW = $clog2(WIDTH + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             first_q, first_d;
    int unsigned      lenEff;

    // State and datapath registers; reset discards any word in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            first_q <= first_d;
        end
    end

    // Next-state logic. The word is left-aligned on capture so the shifter
    // always emits from its top bit; the counter holds the bits remaining
    // after the current one, so zero marks the last bit.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        first_d = first_q;
        lenEff  = eff_len(32'(bus.load_len), WIDTH);

        case (state_q)
            ST_IDLE: begin
                if (bus.load_valid) begin
                    shift_d = bus.load_data << (WIDTH - lenEff);
                    cnt_d   = LW'(lenEff - 1);
                    first_d = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_d = shift_q << 1;
                first_d = 1'b0;
                if (cnt_q == '0) begin
                    if (GAP > 0) begin
                        gap_d   = GW'(GAP - 1);
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only; framing is masked outside SHIFT.
    assign bus.load_ready = (state_q == ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.bit_valid  = (state_q == ST_SHIFT);
    assign bus.serial_ip  = bus.bit_valid & shift_q[WIDTH-1];
    assign bus.sof        = bus.bit_valid & first_q;
    assign bus.eof        = bus.bit_valid & (cnt_q == '0);

endmodule

// File: tb/tb_serial_word_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_word_tx
// Drives two transmitters (GAP=1 and GAP=0) and compares every cycle with a
// queue-based model of the expected output cycles, plus a word/div-by-5
// reconstruction of each received word.
// ---------------------------------------------------------------------------
module tb_serial_word_tx;
    import serial_pkg::*;

    localparam int W = 8;

    typedef struct packed {
        logic       isBit;
        logic       bitVal;
        logic       sof;
        logic       eof;
        logic [7:0] word;
    } rec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             lv  [2];
    logic [W-1:0]     ld  [2];
    logic [LEN_W-1:0] ll  [2];
    logic [5:0]       obs [2];

    rec_t       expQ [2][$];
    bit         started = 1'b0;
    int         testsRun = 0;
    int         testsFailed = 0;
    int         rem [2];
    logic [7:0] acc [2];

    always #5 clk = ~clk;

    // Lane 0 runs with a one-cycle gap, lane 1 with none.
    for (genvar g = 0; g < 2; g++) begin : lane
        serial_word_tx_if #(.WIDTH(W)) bus ();

        assign bus.load_valid = lv[g];
        assign bus.load_data  = ld[g];
        assign bus.load_len   = ll[g];

        serial_word_tx #(.WIDTH(W), .GAP((g == 0) ? 1 : 0)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        assign obs[g] = {bus.load_ready, bus.busy, bus.bit_valid,
                         bus.sof, bus.eof, bus.serial_ip};
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %0h, expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Expands an accepted word into the list of output cycles it produces.
    task automatic pushWord(input int l, input logic [W-1:0] data,
                            input logic [LEN_W-1:0] len);
        int         n;
        logic [7:0] word;
        rec_t       r;
        n    = ((len == 0) || (len > W)) ? W : int'(len);
        word = '0;
        for (int i = n - 1; i >= 0; i--) word = {word[6:0], data[i]};
        for (int i = n - 1; i >= 0; i--) begin
            r = '{isBit: 1'b1, bitVal: data[i], sof: (i == n - 1),
                  eof: (i == 0), word: word};
            expQ[l].push_back(r);
        end
        for (int k = 0; k < ((l == 0) ? 1 : 0); k++) expQ[l].push_back('0);
    endtask

    // Reference model: an empty queue means idle and able to accept.
    always @(posedge clk) begin
        if (!rst_n) begin
            expQ[0].delete();
            expQ[1].delete();
            started = 1'b1;
        end else if (started) begin
            for (int l = 0; l < 2; l++) begin
                if (expQ[l].size() != 0) void'(expQ[l].pop_front());
                else if (lv[l]) pushWord(l, ld[l], ll[l]);
            end
        end
    end

    // Per-cycle comparison and word reassembly, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            for (int l = 0; l < 2; l++) begin
                rec_t       r;
                logic [5:0] ev;
                int         nr;
                logic [7:0] na;
                if (expQ[l].size() == 0) begin
                    ev = 6'b100000;
                end else begin
                    r  = expQ[l][0];
                    ev = {1'b0, 1'b1, r.isBit, r.sof, r.eof, r.bitVal};
                end
                checkOutput($sformatf("outs%0d", l), 32'(obs[l]), 32'(ev));
                if (obs[l][3]) begin
                    nr = ((obs[l][2] ? 0 : rem[l]) * 2 + int'(obs[l][0])) % 5;
                    na = obs[l][2] ? {7'b0, obs[l][0]} : {acc[l][6:0], obs[l][0]};
                    rem[l] = nr;
                    acc[l] = na;
                    if (obs[l][1] && (expQ[l].size() != 0)) begin
                        checkOutput("word", 32'(na), 32'(expQ[l][0].word));
                        checkOutput("div5", 32'(nr == 0),
                                    32'((expQ[l][0].word % 5) == 0));
                    end
                end
            end
        end
    end

    // Waits (bounded) for ready, presents one word for one cycle, then
    // scrambles the inputs so later changes cannot leak into the word.
    task automatic applyStimulus(input int l, input logic [W-1:0] data,
                                 input logic [LEN_W-1:0] len);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (obs[l][5]) begin
                lv[l] = 1'b1;
                ld[l] = data;
                ll[l] = len;
                ok    = 1'b1;
            end
        end
        checkOutput("accept", 32'(ok), 32'd1);
        @(negedge clk);
        lv[l] = 1'b0;
        ld[l] = W'($urandom);
        ll[l] = LEN_W'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int l = 0; l < 2; l++) begin
            lv[l] = 1'b0; ld[l] = '0; ll[l] = '0; rem[l] = 0; acc[l] = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed words on the GAP=1 lane.
        applyStimulus(0, 8'b101, 4'd3);
        applyStimulus(0, 8'b1001, 4'd4);
        applyStimulus(0, 8'b1010, 4'd4);
        applyStimulus(0, 8'hA5, 4'd0);
        applyStimulus(0, 8'h01, 4'd1);
        applyStimulus(0, 8'hFF, 4'd12);

        // Valid held high with changing data while a word is in flight.
        applyStimulus(0, 8'hA5, 4'd8);
        repeat (5) begin
            lv[0] = 1'b1;
            ld[0] = W'($urandom);
            ll[0] = LEN_W'($urandom_range(1, 8));
            @(negedge clk);
        end
        lv[0] = 1'b0;

        // Reset during the second bit of a 4-bit word, then a fresh word.
        applyStimulus(0, 8'h0B, 4'd4);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 8'h06, 4'd4);

        // Back-to-back words on the GAP=0 lane.
        applyStimulus(1, 8'h05, 4'd3);
        lv[1] = 1'b1; ld[1] = 8'h06; ll[1] = 4'd3;
        repeat (20) @(negedge clk);
        lv[1] = 1'b0;

        // Random traffic on both lanes with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                lv[l] = ($urandom_range(0, 2) != 0);
                ld[l] = W'($urandom);
                ll[l] = LEN_W'($urandom_range(0, 15));
            end
            rst_n = ($urandom_range(0, 199) != 0);
        end
        rst_n = 1'b1;
        lv[0] = 1'b0;
        lv[1] = 1'b0;
        repeat (30) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
